// File: rtl/sbox_arbiter.sv
// Shares one pipelined 32-bit AES S-box between key expansion and the round datapath.
// It arbitrates requests, issues words, tags ownership in flight and routes results back.
module sbox_arbiter #(
    parameter int DATA_W     = 32,
    parameter int SBOX_LAT   = 2,
    parameter int MAX_STREAK = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              key_req,
    input  logic [DATA_W-1:0] key_data,
    output logic              key_gnt,
    output logic              key_res_vld,
    output logic [DATA_W-1:0] key_res,

    input  logic              dp_req,
    input  logic [DATA_W-1:0] dp_data,
    output logic              dp_gnt,
    output logic              dp_res_vld,
    output logic [DATA_W-1:0] dp_res,

    output logic              sbox_in_vld,
    output logic [DATA_W-1:0] sbox_in_data,
    input  logic              sbox_out_vld,
    input  logic [DATA_W-1:0] sbox_out_data,

    output logic              busy,
    output logic              err
);

    localparam int STREAK_W = $clog2(MAX_STREAK + 1);

    typedef enum logic {
        OWN_KEY = 1'b0,
        OWN_DP  = 1'b1
    } owner_e;

    typedef struct packed {
        logic   vld;
        owner_e owner;
    } tag_t;

    logic                r_in_vld;
    logic [DATA_W-1:0]   r_in_data;
    owner_e              r_in_owner;
    logic [STREAK_W-1:0] r_streak;
    tag_t                r_tag [SBOX_LAT];
    logic                r_err;

    logic w_streak_full;
    logic w_key_win;
    logic w_dp_win;
    logic w_grant;
    tag_t w_head;
    logic w_tag_any;

    // Nothing is accepted while reset is held, so grants are qualified by it.
    assign w_streak_full = (r_streak == STREAK_W'(MAX_STREAK));
    assign w_dp_win      = reset & dp_req & (~key_req | w_streak_full);
    assign w_key_win     = reset & key_req & ~w_dp_win;
    assign w_grant       = w_key_win | w_dp_win;

    assign key_gnt = w_key_win;
    assign dp_gnt  = w_dp_win;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_in_vld   <= 1'b0;
            r_in_data  <= '0;
            r_in_owner <= OWN_KEY;
        end else begin
            r_in_vld <= w_grant;
            if (w_grant) begin
                r_in_data  <= w_dp_win ? dp_data : key_data;
                r_in_owner <= w_dp_win ? OWN_DP : OWN_KEY;
            end
        end
    end

    // Streak only counts key wins that actually starved a waiting datapath request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_streak <= '0;
        end else if (!dp_req || w_dp_win) begin
            r_streak <= '0;
        end else if (w_key_win && !w_streak_full) begin
            r_streak <= r_streak + STREAK_W'(1);
        end
    end

    // NOTE: the tag stages are a handful of flops, not a RAM, so clearing them on
    // reset is cheap and is what drops in-flight ownership on a mid-flight reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SBOX_LAT; i++) begin
                r_tag[i] <= '{vld: 1'b0, owner: OWN_KEY};
            end
        end else begin
            r_tag[0] <= '{vld: r_in_vld, owner: r_in_owner};
            for (int i = 1; i < SBOX_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_head = r_tag[SBOX_LAT-1];

    // An untagged result, or a missing one, poisons the block until the next reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (sbox_out_vld != w_head.vld) begin
            r_err <= 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default before the loop, so no latch forms.
    always_comb begin
        w_tag_any = 1'b0;
        for (int i = 0; i < SBOX_LAT; i++) begin
            w_tag_any = w_tag_any | r_tag[i].vld;
        end
    end

    assign key_res_vld = sbox_out_vld & w_head.vld & (w_head.owner == OWN_KEY);
    assign dp_res_vld  = sbox_out_vld & w_head.vld & (w_head.owner == OWN_DP);
    assign key_res     = sbox_out_data;
    assign dp_res      = sbox_out_data;

    assign sbox_in_vld  = r_in_vld;
    assign sbox_in_data = r_in_data;
    assign busy         = r_in_vld | w_tag_any;
    assign err          = r_err;

endmodule

// File: tb/tb_sbox_arbiter.sv
// Directed bench for sbox_arbiter with a behavioural AES S-box pipeline and an
// ownership/order/latency scoreboard on the returned results.
module tb_sbox_arbiter;

    localparam int DATA_W     = 32;
    localparam int SBOX_LAT   = 2;
    localparam int MAX_STREAK = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              key_req = 1'b0;
    logic [DATA_W-1:0] key_data = '0;
    logic              key_gnt, key_res_vld;
    logic [DATA_W-1:0] key_res;
    logic              dp_req = 1'b0;
    logic [DATA_W-1:0] dp_data = '0;
    logic              dp_gnt, dp_res_vld;
    logic [DATA_W-1:0] dp_res;
    logic              sbox_in_vld;
    logic [DATA_W-1:0] sbox_in_data;
    logic              sbox_out_vld;
    logic [DATA_W-1:0] sbox_out_data;
    logic              busy, err;

    logic              suppress = 1'b0;
    logic [SBOX_LAT-1:0] m_vld = '0;
    logic [DATA_W-1:0] m_dat [SBOX_LAT] = '{default: '0};

    typedef struct {
        logic              own;
        logic [DATA_W-1:0] res;
        int                cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc   = 0;

    sbox_arbiter #(
        .DATA_W(DATA_W), .SBOX_LAT(SBOX_LAT), .MAX_STREAK(MAX_STREAK)
    ) dut (
        .clock(clock), .reset(reset),
        .key_req(key_req), .key_data(key_data), .key_gnt(key_gnt),
        .key_res_vld(key_res_vld), .key_res(key_res),
        .dp_req(dp_req), .dp_data(dp_data), .dp_gnt(dp_gnt),
        .dp_res_vld(dp_res_vld), .dp_res(dp_res),
        .sbox_in_vld(sbox_in_vld), .sbox_in_data(sbox_in_data),
        .sbox_out_vld(sbox_out_vld), .sbox_out_data(sbox_out_data),
        .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] a);
        logic [7:0] inv = '0;
        for (int i = 1; i < 256; i++) begin
            if (gmul(a, 8'(i)) == 8'h01) inv = 8'(i);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [DATA_W-1:0] sbox_word(input logic [DATA_W-1:0] w);
        return {sbox_byte(w[31:24]), sbox_byte(w[23:16]), sbox_byte(w[15:8]), sbox_byte(w[7:0])};
    endfunction

    // Behavioural S-box: not reset by the DUT reset, so in-flight words still emerge.
    always @(posedge clock) begin
        m_vld[0] <= sbox_in_vld;
        m_dat[0] <= sbox_word(sbox_in_data);
        for (int i = 1; i < SBOX_LAT; i++) begin
            m_vld[i] <= m_vld[i-1];
            m_dat[i] <= m_dat[i-1];
        end
    end

    assign sbox_out_vld  = m_vld[SBOX_LAT-1] & ~suppress;
    assign sbox_out_data = m_dat[SBOX_LAT-1];

    always @(posedge clock) cyc = cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: push on accepted requests, pop and compare on each returned result.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            if (key_req && key_gnt) begin
                e.own = 1'b0; e.res = sbox_word(key_data); e.cyc = cyc + 1 + SBOX_LAT;
                sb_q.push_back(e);
            end
            if (dp_req && dp_gnt) begin
                e.own = 1'b1; e.res = sbox_word(dp_data); e.cyc = cyc + 1 + SBOX_LAT;
                sb_q.push_back(e);
            end
            if (key_res_vld || dp_res_vld) begin
                check("res_single_owner", 64'({key_res_vld, dp_res_vld} != 2'b11), 64'd1);
                check("res_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("res_owner", 64'(dp_res_vld), 64'(e.own));
                    check("res_data", 64'(dp_res_vld ? dp_res : key_res), 64'(e.res));
                    check("res_latency", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    logic [DATA_W-1:0] dp_exp [4] = '{32'h63636363, 32'h6363637C, 32'h63636377, 32'h6363637B};
    logic [DATA_W-1:0] kcnt, dcnt;
    logic              exp_d;

    initial begin
        // Reset state, with a key request held to show nothing is granted in reset.
        key_req = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_vld", 64'(sbox_in_vld), 64'd0);
        check("rst_in_data", 64'(sbox_in_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_key_gnt", 64'(key_gnt), 64'd0);
        check("rst_res_vld", 64'({key_res_vld, dp_res_vld}), 64'd0);
        key_req = 1'b0;
        reset   = 1'b1;

        // Single key lookup.
        tick();
        key_req = 1'b1; key_data = 32'h00530000;
        #1;
        check("k1_key_gnt", 64'(key_gnt), 64'd1);
        check("k1_dp_gnt", 64'(dp_gnt), 64'd0);
        tick();
        key_req = 1'b0; key_data = '0;
        #1;
        check("k1_in_vld", 64'(sbox_in_vld), 64'd1);
        check("k1_in_data", 64'(sbox_in_data), 64'h00530000);
        check("k1_busy", 64'(busy), 64'd1);
        tick();
        check("k1_early", 64'(key_res_vld), 64'd0);
        tick();
        check("k1_res_vld", 64'(key_res_vld), 64'd1);
        check("k1_res", 64'(key_res), 64'h63ED6363);
        check("k1_dp_vld", 64'(dp_res_vld), 64'd0);
        tick();
        check("k1_idle_busy", 64'(busy), 64'd0);
        check("k1_idle_vld", 64'(key_res_vld), 64'd0);

        // Both requesting for 10 cycles: K,K,K,K,D repeated.
        kcnt = 32'h01020300; dcnt = 32'h0A0B0C00;
        for (int i = 0; i < 10; i++) begin
            key_req = 1'b1; dp_req = 1'b1;
            key_data = kcnt; dp_data = dcnt;
            exp_d = (i == 4) || (i == 9);
            #1;
            check($sformatf("arb_key_gnt_%0d", i), 64'(key_gnt), 64'(!exp_d));
            check($sformatf("arb_dp_gnt_%0d", i), 64'(dp_gnt), 64'(exp_d));
            if (key_gnt) kcnt = kcnt + 1;
            if (dp_gnt)  dcnt = dcnt + 1;
            tick();
        end
        key_req = 1'b0; dp_req = 1'b0;
        repeat (5) tick();
        check("arb_drained", 64'(sb_q.size()), 64'd0);

        // Datapath only, four back-to-back words.
        for (int i = 0; i < 8; i++) begin
            dp_req  = (i < 4);
            dp_data = (i < 4) ? DATA_W'(i) : '0;
            #1;
            if (i < 4) check($sformatf("dp4_gnt_%0d", i), 64'(dp_gnt), 64'd1);
            if (i >= 3 && i < 7) begin
                check($sformatf("dp4_vld_%0d", i - 3), 64'(dp_res_vld), 64'd1);
                check($sformatf("dp4_res_%0d", i - 3), 64'(dp_res), 64'(dp_exp[i-3]));
                check($sformatf("dp4_key_vld_%0d", i - 3), 64'(key_res_vld), 64'd0);
            end
            if (i == 7) check("dp4_gap_after", 64'(dp_res_vld), 64'd0);
            tick();
        end
        dp_req = 1'b0;
        repeat (3) tick();
        check("dp4_drained", 64'(sb_q.size()), 64'd0);

        // Interleaved K,D,K issue.
        for (int i = 0; i < 7; i++) begin
            key_req  = (i == 0) || (i == 2);
            dp_req   = (i == 1);
            key_data = (i == 0) ? 32'h11223344 : 32'hFFFFFFFF;
            dp_data  = 32'hA5A5A5A5;
            #1;
            if (i < 3) begin
                check($sformatf("kdk_key_gnt_%0d", i), 64'(key_gnt), 64'(i != 1));
                check($sformatf("kdk_dp_gnt_%0d", i), 64'(dp_gnt), 64'(i == 1));
            end
            if (i >= 3 && i < 6) begin
                check($sformatf("kdk_key_vld_%0d", i), 64'(key_res_vld), 64'(i != 4));
                check($sformatf("kdk_dp_vld_%0d", i), 64'(dp_res_vld), 64'(i == 4));
            end
            tick();
        end
        key_req = 1'b0; dp_req = 1'b0;
        repeat (3) tick();
        check("kdk_drained", 64'(sb_q.size()), 64'd0);

        // Reset with two words in flight; the stray result afterwards must raise err.
        for (int i = 0; i < 2; i++) begin
            key_req = 1'b1; key_data = 32'hC0DE0000 + DATA_W'(i);
            tick();
        end
        key_req = 1'b0;
        reset = 1'b0;
        sb_q.delete();
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_res_vld", 64'({key_res_vld, dp_res_vld}), 64'd0);
        check("mid_rst_in_vld", 64'(sbox_in_vld), 64'd0);
        reset = 1'b1;
        tick();
        check("stray_no_res", 64'({key_res_vld, dp_res_vld}), 64'd0);
        check("stray_err_pre", 64'(err), 64'd0);
        tick();
        check("stray_err", 64'(err), 64'd1);
        tick();
        check("stray_err_held", 64'(err), 64'd1);
        check("stray_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        #1;
        check("err_cleared", 64'(err), 64'd0);
        reset = 1'b1;

        // Missing S-box result while a tag is at the head.
        tick();
        key_req = 1'b1; key_data = 32'h01234567;
        tick();
        key_req = 1'b0;
        tick();
        tick();
        suppress = 1'b1;
        #1;
        check("miss_no_res", 64'(key_res_vld), 64'd0);
        check("miss_err_pre", 64'(err), 64'd0);
        tick();
        suppress = 1'b0;
        check("miss_err", 64'(err), 64'd1);
        repeat (3) tick();
        check("miss_err_held", 64'(err), 64'd1);
        sb_q.delete();
        reset = 1'b0;
        #1;
        check("miss_err_cleared", 64'(err), 64'd0);
        reset = 1'b1;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
